// File: rtl/plic_prio.sv
// plic_prio: priority interrupt controller with per-source level/edge gateways, threshold and claim/complete.
module plic_prio #(
    parameter int                NUM_SRC   = 8,
    parameter int                PRIO_W    = 3,
    parameter logic [NUM_SRC:1]  EDGE_MASK = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_i,
    input  logic [3:0]         we_i,
    input  logic [23:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    input  logic [NUM_SRC:1]   irq_i,
    output logic               irq_o,
    output logic [NUM_SRC:1]   iack_o
);
    logic [NUM_SRC:1]  pending, inflight, deferred, irq_q, ie;
    logic [NUM_SRC:1]  pending_n, inflight_n, deferred_n, rise, busy, claim_hit, comp_hit;
    logic [PRIO_W-1:0] prio [1:NUM_SRC];
    logic [PRIO_W-1:0] threshold, best_prio, prio_rd;
    logic [4:0]        best_id;
    logic [9:0]        idx;
    logic [31:0]       rd_data;
    logic              wr, rd, sel_prio, sel_pend, sel_ie, sel_thr, sel_cc;
    logic              unused_data;

    assign unused_data = ^data_i;
    assign wr       = en_i && |we_i;
    assign rd       = en_i && ~|we_i;
    assign idx      = addr_i[11:2];
    assign sel_prio = addr_i[23:12] == 12'h0 && addr_i[1:0] == 2'b00 && idx != 10'd0 && idx <= 10'(NUM_SRC);
    assign sel_pend = addr_i == 24'h001000;
    assign sel_ie   = addr_i == 24'h002000;
    assign sel_thr  = addr_i == 24'h200000;
    assign sel_cc   = addr_i == 24'h200004;

    // Descending scan with >= leaves the lowest ID holding a tie.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        prio_rd   = '0;
        claim_hit = '0;
        comp_hit  = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (pending[i] && ie[i] && prio[i] != '0 && prio[i] >= best_prio) begin
                best_id   = 5'(i);
                best_prio = prio[i];
            end
        end
        for (int i = 1; i <= NUM_SRC; i++) begin
            prio_rd      = idx == 10'(i) ? prio[i] : prio_rd;
            claim_hit[i] = rd && sel_cc && best_id == 5'(i);
            comp_hit[i]  = wr && sel_cc && data_i[4:0] == 5'(i) && inflight[i];
        end
    end

    assign rd_data = sel_prio ? 32'(prio_rd) :
                     sel_pend ? 32'({pending, 1'b0}) :
                     sel_ie   ? 32'({ie, 1'b0}) :
                     sel_thr  ? 32'(threshold) :
                     sel_cc   ? 32'(best_id) : '0;

    // A completing edge source re-arms from its deferred bit or a rise seen on that same edge.
    assign rise       = irq_i & ~irq_q;
    assign busy       = pending | inflight;
    assign pending_n  = (pending & ~claim_hit) | (~EDGE_MASK & irq_i & ~busy) |
                        (EDGE_MASK & ((rise & ~busy) | (comp_hit & (deferred | rise))));
    assign deferred_n = EDGE_MASK & ~comp_hit & (deferred | (rise & busy));
    assign inflight_n = (inflight & ~comp_hit) | claim_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= '0;
            inflight  <= '0;
            deferred  <= '0;
            irq_q     <= '0;
            ie        <= '0;
            threshold <= '0;
            data_o    <= '0;
            irq_o     <= 1'b0;
            iack_o    <= '0;
            for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
        end else begin
            pending  <= pending_n;
            inflight <= inflight_n;
            deferred <= deferred_n;
            irq_q    <= irq_i;
            irq_o    <= best_prio > threshold;
            iack_o   <= comp_hit;
            if (rd) data_o <= rd_data;
            if (wr && sel_ie) ie <= data_i[NUM_SRC:1];
            if (wr && sel_thr) threshold <= data_i[PRIO_W-1:0];
            for (int i = 1; i <= NUM_SRC; i++)
                if (wr && sel_prio && idx == 10'(i)) prio[i] <= data_i[PRIO_W-1:0];
        end
    end
endmodule
